// File: rtl/regfile_pkg.sv
// Shared defaults for the parameterised register file and the address-width derivation.
package regfile_pkg;

   localparam int DEF_WIDTH    = 64;
   localparam int DEF_DEPTH    = 32;
   localparam int DEF_NRD      = 2;
   localparam int DEF_ZERO_REG = 31;
   localparam int DEF_BYPASS   = 1;

   // A one-entry file still needs a one-bit address bus.
   function automatic int addr_width(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   localparam int DEF_AW = addr_width(DEF_DEPTH);

endpackage

// File: rtl/regfile_param_reg.sv
// One WIDTH-bit storage register with write enable and asynchronous active-low clear.
module regfile_param_reg
   import regfile_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic [WIDTH-1:0] d,
   input  logic             wren,
   input  logic             clk,
   input  logic             reset,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] r_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_q <= '0;
      end else if (wren) begin
         r_q <= d;
      end
   end

   assign q = r_q;

endmodule

// File: rtl/regfile_param.sv
// Multi-port register file with a hardwired zero register, optional write-to-read
// forwarding and a per-register pending (scoreboard) bit.
module regfile_param
   import regfile_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int NRD      = DEF_NRD,
   parameter int ZERO_REG = DEF_ZERO_REG,
   parameter int BYPASS   = DEF_BYPASS,
   localparam int AW      = addr_width(DEPTH)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [WIDTH-1:0]     WriteData,
   input  logic [AW-1:0]        WriteRegister,
   input  logic                 RegWrite,
   input  logic [NRD*AW-1:0]    ReadRegister,
   output logic [NRD*WIDTH-1:0] ReadData,
   input  logic                 Reserve,
   input  logic [AW-1:0]        ReserveRegister,
   output logic [NRD-1:0]       Pending
);

   // An address is backed by storage only if it exists and is not the zero register.
   function automatic logic addr_legal(input logic [AW-1:0] a);
      return ({1'b0, a} < (AW+1)'(DEPTH)) && (a != AW'(ZERO_REG));
   endfunction

   logic             w_wr_legal;
   logic             w_rsv_legal;
   logic [WIDTH-1:0] w_q [DEPTH];
   logic [DEPTH-1:0] w_pend;

   assign w_wr_legal  = RegWrite && addr_legal(WriteRegister);
   assign w_rsv_legal = Reserve && addr_legal(ReserveRegister);

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
      if (gi == ZERO_REG) begin : g_zero
         assign w_q[gi]    = '0;
         assign w_pend[gi] = 1'b0;
      end else begin : g_store
         logic w_wren;
         logic w_rsv_hit;
         logic r_pending;

         assign w_wren    = w_wr_legal && (WriteRegister == AW'(gi));
         assign w_rsv_hit = w_rsv_legal && (ReserveRegister == AW'(gi));

         regfile_param_reg #(
            .WIDTH (WIDTH)
         ) u_reg (
            .d     (WriteData),
            .wren  (w_wren),
            .clk   (clk),
            .reset (reset),
            .q     (w_q[gi])
         );

         // A new reservation outranks the completing write of an older producer.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               r_pending <= 1'b0;
            end else if (w_rsv_hit) begin
               r_pending <= 1'b1;
            end else if (w_wren) begin
               r_pending <= 1'b0;
            end
         end

         assign w_pend[gi] = r_pending;
      end
   end

   for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] w_addr;
      logic          w_ok;
      logic          w_fwd;

      assign w_addr = ReadRegister[gi*AW +: AW];
      assign w_ok   = addr_legal(w_addr);
      assign w_fwd  = (BYPASS != 0) && w_wr_legal && (WriteRegister == w_addr);

      assign ReadData[gi*WIDTH +: WIDTH] = !w_ok ? '0 :
                                           w_fwd ? WriteData : w_q[w_addr];
      assign Pending[gi] = w_ok && !w_fwd && w_pend[w_addr];
   end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: default, no-bypass and narrow/3-port instances.
module tb_regfile_param;

   typedef struct {
      string        tag;
      logic [127:0] exp;
   } sb_t;

   sb_t sb[$];
   int  checks = 0;
   int  errors = 0;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic [63:0]  wd;
   logic [4:0]   wr;
   logic         we;
   logic [9:0]   rr;
   logic         rsv;
   logic [4:0]   rsvr;
   logic [127:0] rd_a, rd_b;
   logic [1:0]   pend_a, pend_b;

   logic [31:0]  wd_c;
   logic [3:0]   wr_c;
   logic         we_c;
   logic [11:0]  rr_c;
   logic         rsv_c;
   logic [3:0]   rsvr_c;
   logic [95:0]  rd_c;
   logic [2:0]   pend_c;

   regfile_param u_dut_a (
      .clk(clk), .reset(reset), .WriteData(wd), .WriteRegister(wr), .RegWrite(we),
      .ReadRegister(rr), .ReadData(rd_a), .Reserve(rsv), .ReserveRegister(rsvr),
      .Pending(pend_a)
   );

   regfile_param #(.BYPASS(0)) u_dut_b (
      .clk(clk), .reset(reset), .WriteData(wd), .WriteRegister(wr), .RegWrite(we),
      .ReadRegister(rr), .ReadData(rd_b), .Reserve(rsv), .ReserveRegister(rsvr),
      .Pending(pend_b)
   );

   regfile_param #(.WIDTH(32), .DEPTH(16), .NRD(3), .ZERO_REG(15)) u_dut_c (
      .clk(clk), .reset(reset), .WriteData(wd_c), .WriteRegister(wr_c), .RegWrite(we_c),
      .ReadRegister(rr_c), .ReadData(rd_c), .Reserve(rsv_c), .ReserveRegister(rsvr_c),
      .Pending(pend_c)
   );

   localparam logic [63:0] V5   = 64'hDEADBEEF_CAFEF00D;
   localparam logic [31:0] V5C  = 32'hCAFEF00D;

   function automatic logic [63:0] pat(input int r);
      return {32'(r) ^ 32'hA5A5_0000, 32'(r) * 32'h0101_0101};
   endfunction

   function automatic logic [31:0] pat_c(input int r);
      return (32'(r) * 32'h0101_0101) ^ 32'h0000_005A;
   endfunction

   task automatic push(input string tag, input logic [127:0] v);
      sb.push_back('{tag, v});
   endtask

   task automatic check(input logic [127:0] obs);
      sb_t e;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_underflow observed=%0h expected=<entry>", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
         end
      end
   endtask

   // Every address of every instance reads zero with no pending bit.
   task automatic check_all_zero(input string tag);
      for (int a = 0; a < 32; a++) begin
         @(negedge clk);
         rr   = {5'(a), 5'(a)};
         rr_c = {4'(a % 16), 4'(a % 16), 4'(a % 16)};
         push({tag, "_rd_a"}, '0);
         push({tag, "_pd_a"}, '0);
         push({tag, "_rd_b"}, '0);
         push({tag, "_pd_b"}, '0);
         push({tag, "_rd_c"}, '0);
         push({tag, "_pd_c"}, '0);
         #1;
         check(rd_a);
         check(pend_a);
         check(rd_b);
         check(pend_b);
         check(rd_c);
         check(pend_c);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      wd = '0; wr = '0; we = 1'b0; rr = '0; rsv = 1'b0; rsvr = '0;
      wd_c = '0; wr_c = '0; we_c = 1'b0; rr_c = '0; rsv_c = 1'b0; rsvr_c = '0;

      check_all_zero("reset");
      @(negedge clk);
      reset = 1'b1;

      // Write reg 5, read it on all ports next cycle.
      @(negedge clk);
      we = 1'b1; wr = 5'd5; wd = V5;
      we_c = 1'b1; wr_c = 4'd5; wd_c = V5C;
      @(negedge clk);
      we = 1'b0; we_c = 1'b0;
      rr = {5'd5, 5'd5}; rr_c = {4'd5, 4'd5, 4'd5};
      push("wr5_rd_a", {V5, V5});
      push("wr5_rd_b", {V5, V5});
      push("wr5_rd_c", {V5C, V5C, V5C});
      #1;
      check(rd_a); check(rd_b); check(rd_c);

      // Writes to the zero register are never visible, not even via bypass.
      @(negedge clk);
      we = 1'b1; wr = 5'd31; wd = '1; rr = {5'd31, 5'd31};
      we_c = 1'b1; wr_c = 4'd15; wd_c = '1; rr_c = {4'd15, 4'd15, 4'd15};
      push("zr_byp_rd_a", '0);
      push("zr_byp_rd_c", '0);
      #1;
      check(rd_a); check(rd_c);
      @(negedge clk);
      we = 1'b0; we_c = 1'b0;
      push("zr_rd_a", '0);
      push("zr_rd_b", '0);
      push("zr_rd_c", '0);
      push("zr_pd_a", '0);
      #1;
      check(rd_a); check(rd_b); check(rd_c); check(pend_a);

      // Same-cycle forwarding on port 0 only where BYPASS is enabled.
      @(negedge clk);
      we = 1'b1; wr = 5'd7; wd = 64'h1234; rr = {5'd5, 5'd7};
      we_c = 1'b1; wr_c = 4'd7; wd_c = 32'h1234; rr_c = {4'd5, 4'd5, 4'd7};
      push("byp_rd_a", {V5, 64'h1234});
      push("byp_rd_b", {V5, 64'h0});
      push("byp_rd_c", {V5C, V5C, 32'h1234});
      #1;
      check(rd_a); check(rd_b); check(rd_c);
      @(negedge clk);
      we = 1'b0; we_c = 1'b0;
      push("post_rd_a", {V5, 64'h1234});
      push("post_rd_b", {V5, 64'h1234});
      push("post_rd_c", {V5C, V5C, 32'h1234});
      #1;
      check(rd_a); check(rd_b); check(rd_c);

      // Reserve reg 3: pending visible only after the edge.
      @(negedge clk);
      rsv = 1'b1; rsvr = 5'd3; rr = {5'd3, 5'd3};
      rsv_c = 1'b1; rsvr_c = 4'd3; rr_c = {4'd3, 4'd3, 4'd3};
      push("rsv_pre_pd_a", '0);
      push("rsv_pre_pd_c", '0);
      #1;
      check(pend_a); check(pend_c);
      @(negedge clk);
      rsv = 1'b0; rsv_c = 1'b0;
      push("rsv_pd_a", 2'b11);
      push("rsv_pd_b", 2'b11);
      push("rsv_pd_c", 3'b111);
      #1;
      check(pend_a); check(pend_b); check(pend_c);

      // Write reg 3 clears pending; bypass hides it during the write cycle.
      @(negedge clk);
      we = 1'b1; wr = 5'd3; wd = 64'hAAAA;
      we_c = 1'b1; wr_c = 4'd3; wd_c = 32'hAAAA;
      push("wr3_byp_pd_a", 2'b00);
      push("wr3_byp_pd_b", 2'b11);
      push("wr3_byp_pd_c", 3'b000);
      push("wr3_byp_rd_a", {64'hAAAA, 64'hAAAA});
      push("wr3_byp_rd_b", '0);
      #1;
      check(pend_a); check(pend_b); check(pend_c); check(rd_a); check(rd_b);
      @(negedge clk);
      we = 1'b0; we_c = 1'b0;
      push("wr3_pd_a", 2'b00);
      push("wr3_pd_b", 2'b00);
      push("wr3_pd_c", 3'b000);
      push("wr3_rd_b", {64'hAAAA, 64'hAAAA});
      #1;
      check(pend_a); check(pend_b); check(pend_c); check(rd_b);

      // Reserve and write of reg 3 on one edge: pending set, data still updated.
      @(negedge clk);
      we = 1'b1; wr = 5'd3; wd = 64'h5555; rsv = 1'b1; rsvr = 5'd3;
      we_c = 1'b1; wr_c = 4'd3; wd_c = 32'h5555; rsv_c = 1'b1; rsvr_c = 4'd3;
      @(negedge clk);
      we = 1'b0; rsv = 1'b0; we_c = 1'b0; rsv_c = 1'b0;
      push("rsvwr_pd_a", 2'b11);
      push("rsvwr_pd_b", 2'b11);
      push("rsvwr_pd_c", 3'b111);
      push("rsvwr_rd_a", {64'h5555, 64'h5555});
      push("rsvwr_rd_c", {32'h5555, 32'h5555, 32'h5555});
      #1;
      check(pend_a); check(pend_b); check(pend_c); check(rd_a); check(rd_c);

      // Reserving the zero register is ignored.
      @(negedge clk);
      rsv = 1'b1; rsvr = 5'd31; rr = {5'd31, 5'd31};
      rsv_c = 1'b1; rsvr_c = 4'd15; rr_c = {4'd15, 4'd15, 4'd15};
      @(negedge clk);
      rsv = 1'b0; rsv_c = 1'b0;
      push("rsvzr_pd_a", '0);
      push("rsvzr_pd_c", '0);
      #1;
      check(pend_a); check(pend_c);

      // Fill registers 1..30 (1..14 on the narrow instance), reserve reg 10 on the last edge.
      for (int r = 1; r <= 30; r++) begin
         @(negedge clk);
         we = 1'b1; wr = 5'(r); wd = pat(r);
         we_c = (r <= 14); wr_c = 4'(r); wd_c = pat_c(r);
         rsv = (r == 30); rsvr = 5'd10;
         rsv_c = (r == 30); rsvr_c = 4'd10;
      end
      @(negedge clk);
      we = 1'b0; we_c = 1'b0; rsv = 1'b0; rsv_c = 1'b0;
      rr = {5'd1, 5'd30}; rr_c = {4'd14, 4'd1, 4'd10};
      push("fill_rd_a", {pat(1), pat(30)});
      push("fill_rd_b", {pat(1), pat(30)});
      push("fill_rd_c", {pat_c(14), pat_c(1), pat_c(10)});
      push("fill_pd_c", 3'b001);
      #1;
      check(rd_a); check(rd_b); check(rd_c); check(pend_c);
      @(negedge clk);
      rr = {5'd10, 5'd10};
      push("fill_pd_a", 2'b11);
      #1;
      check(pend_a);

      // Mid-cycle reset with a coincident write and reserve that must be discarded.
      @(posedge clk);
      #2;
      reset = 1'b0;
      we = 1'b1; wr = 5'd4; wd = '1; rsv = 1'b1; rsvr = 5'd4;
      we_c = 1'b1; wr_c = 4'd4; wd_c = '1; rsv_c = 1'b1; rsvr_c = 4'd4;
      rr = {5'd10, 5'd30}; rr_c = {4'd10, 4'd14, 4'd1};
      push("arst_rd_a", '0);
      push("arst_pd_a", '0);
      push("arst_rd_c", '0);
      push("arst_pd_c", '0);
      #1;
      check(rd_a); check(pend_a); check(rd_c); check(pend_c);
      we = 1'b0; rsv = 1'b0; we_c = 1'b0; rsv_c = 1'b0;
      check_all_zero("arst");

      // First edge after release already accepts a write.
      @(negedge clk);
      reset = 1'b1;
      we = 1'b1; wr = 5'd2; wd = 64'h77;
      we_c = 1'b1; wr_c = 4'd2; wd_c = 32'h77;
      @(negedge clk);
      we = 1'b0; we_c = 1'b0;
      rr = {5'd4, 5'd2}; rr_c = {4'd4, 4'd4, 4'd2};
      push("rel_rd_a", {64'h0, 64'h77});
      push("rel_rd_b", {64'h0, 64'h77});
      push("rel_rd_c", {32'h0, 32'h0, 32'h77});
      #1;
      check(rd_a); check(rd_b); check(rd_c);

      checks++;
      assert (sb.size() == 0) else begin
         errors++;
         $error("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/regfile_param.md
REGFILE_PARAM -- requirements
Module: regfile_param

Interface
REQ-001 The block SHALL have parameter WIDTH, default 64, data bits per register.
REQ-002 The block SHALL have parameter DEPTH, default 32, number of architectural registers; AW = $clog2(DEPTH).
REQ-003 The block SHALL have parameter NRD, default 2, number of independent read ports.
REQ-004 The block SHALL have parameter ZERO_REG, default 31, index hardwired to zero.
REQ-005 The block SHALL have parameter BYPASS, default 1, 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-006 The block SHALL have port clk, input, 1, single clock; all state updates on posedge.
REQ-007 The block SHALL have port reset, input, 1, asynchronous, active-low; clears all state.
REQ-008 The block SHALL have port WriteData, input, WIDTH, write data.
REQ-009 The block SHALL have port WriteRegister, input, AW, write address.
REQ-010 The block SHALL have port RegWrite, input, 1, write enable.
REQ-011 The block SHALL have port ReadRegister, input, NRD*AW, packed read addresses; port k at bits [k*AW +: AW].
REQ-012 The block SHALL have port ReadData, output, NRD*WIDTH, packed read data; port k at [k*WIDTH +: WIDTH].
REQ-013 The block SHALL have port Reserve, input, 1, marks ReserveRegister pending (outstanding producer).
REQ-014 The block SHALL have port ReserveRegister, input, AW, register to reserve.
REQ-015 The block SHALL have port Pending, output, NRD, pending status of each read port's addressed register.

Function
REQ-016 A write SHALL occur at posedge clk when RegWrite=1, WriteRegister != ZERO_REG and WriteRegister < DEPTH; otherwise no register changes.
REQ-017 Reads SHALL be combinational: ReadData[k] = contents of ReadRegister[k], zero latency.
REQ-018 A read of ZERO_REG or of an address >= DEPTH SHALL return all zeros, regardless of writes or bypass.
REQ-019 With BYPASS=1, when RegWrite=1 and WriteRegister == ReadRegister[k] and the write is legal per REQ-016, ReadData[k] SHALL equal WriteData in that same cycle.
REQ-020 With BYPASS=0, ReadData[k] SHALL show the old value until the cycle after the write edge.
REQ-021 Each register SHALL have one pending bit; Reserve=1 at posedge sets pending[ReserveRegister]; a legal write clears pending[WriteRegister].
REQ-022 Reserve and write to the same register on the same edge: set SHALL win (pending = 1, data still written).
REQ-023 Reserve of ZERO_REG or of an address >= DEPTH SHALL be ignored; ZERO_REG pending is constant 0.
REQ-024 Pending[k] SHALL equal pending[ReadRegister[k]]; with BYPASS=1 it SHALL read 0 while a legal write to that register is in progress in the same cycle.
REQ-025 Multiple read ports addressing the same register SHALL return identical data and pending values.

Reset
REQ-026 While reset=0 all registers SHALL be cleared to 0 and all pending bits to 0 immediately, without waiting for clk.
REQ-027 A write or reserve coinciding with reset assertion SHALL be discarded.
REQ-028 After reset deassertion, writes SHALL take effect from the first posedge where reset=1.

Structure
REQ-029 Default parameter values and the AW derivation SHALL be placed in shared package regfile_pkg.
REQ-030 One WIDTH-bit enabled register SHALL be a sub-module named regfile_param_reg (d, wren, clk, reset, q), instantiated DEPTH-1 times; ZERO_REG SHALL NOT be instantiated as storage.

Verification
REQ-031 Reset then read all addresses on both ports -> ReadData = 0, Pending = 0.
REQ-032 Write 64'hDEADBEEF_CAFEF00D to reg 5, next cycle ReadRegister = {5,5} -> both ports return it; write reg 31 -> reads stay 0.
REQ-033 BYPASS=1: RegWrite to reg 7 with 64'h1234 while port 0 reads 7 -> ReadData[0] = 64'h1234 same cycle; BYPASS=0 -> old value, then 64'h1234 after edge.
REQ-034 Reserve reg 3 -> Pending=1 next cycle; write reg 3 -> Pending=0 after edge; same-edge reserve+write reg 3 -> Pending=1, data updated.
REQ-035 Assert reset mid-cycle between edges after writing regs 1..30 -> all reads 0 immediately, pending cleared.
REQ-036 Parameter sweep WIDTH=32, DEPTH=16, NRD=3, ZERO_REG=15 -> REQ-031..034 pass; reads of address 15 return 0.
